sc_statemachine_backg: RTL and testbench
========================================

# sc_statemachine_backg

Background game sequencer for the LED-matrix game. It decodes debounced start presses and the speed comparator's terminal flag. It drives the active-low control strobes of the speed prescaler counter, the level register and the background shift registers. It sits between the debounce/speed-compare stage and the game registers that feed the matrix controller.

## Interface

- SHIFTS_PER_LEVEL, 8, number of background shifts between level-up strobes (2..15)
- ROWCOUNT_DATAWIDTH, 4, width of internal shift counter
- SC_STATEMACHINEBACKG_CLOCK_50  in  1  system clock, 50 MHz; the block's only clock
- SC_STATEMACHINEBACKG_RESET_InLow  in  1  reset; synchronous, active-low
- SC_STATEMACHINEBACKG_startButton_InLow  in  1  debounced start button, 0 = pressed
- SC_STATEMACHINEBACKG_T0_InLow  in  1  speed comparator terminal, 0 = prescaler period elapsed
- SC_STATEMACHINEBACKG_gameOver_InLow  in  1  collision flag, 0 = game lost
- SC_STATEMACHINEBACKG_clear_OutLow  out  1  level register clear strobe
- SC_STATEMACHINEBACKG_load_OutLow  out  1  level register load (level advance) strobe
- SC_STATEMACHINEBACKG_upcount_OutLow  out  1  speed counter count enable
- SC_STATEMACHINEBACKG_speedClear_OutLow  out  1  speed counter clear strobe
- SC_STATEMACHINEBACKG_shift_OutLow  out  1  background shift strobe
- SC_STATEMACHINEBACKG_state_OutBUS  out  3  current state code, for debug/LEDs

## Operation

- Moore FSM. Outputs are decoded from the state register only. All strobes are active-low and inactive (1) unless listed for a state.
- Start edge: the previous start sample is held in a register, reset value 1. Edge = previous 1 and current 0, one cycle per press. A held button produces no further edges.
- State codes:
  - IDLE = 0, INIT = 1, COUNT = 2, SHIFT = 3
  - LEVELUP = 4, PAUSE = 5, GAMEOVER = 6
  - Code 7 is illegal and goes to IDLE next cycle.
- IDLE: no strobes. Start edge goes to INIT.
- INIT, one cycle:
  - clear_OutLow = 0 and speedClear_OutLow = 0.
  - Shift counter is set to 0.
  - Next state is COUNT.
- COUNT: upcount_OutLow = 0. Next-state priority:
  1. gameOver = 0 goes to GAMEOVER.
  2. Otherwise, a start edge goes to PAUSE.
  3. Otherwise, T0 = 0 goes to SHIFT.
  4. Otherwise, stay in COUNT.
- SHIFT, one cycle:
  - shift_OutLow = 0 and speedClear_OutLow = 0.
  - If the shift counter = SHIFTS_PER_LEVEL-1: counter goes to 0 and next state is LEVELUP.
  - Otherwise: counter increments by 1 and next state is COUNT.
- LEVELUP, one cycle: load_OutLow = 0, then COUNT. Level saturation is the level register's responsibility.
- PAUSE: no strobes; the prescaler holds its value.
  - gameOver = 0 goes to GAMEOVER.
  - Otherwise, a start edge goes to COUNT.
- GAMEOVER: no strobes. Start edge goes to INIT, which restarts the game.
- Shift counter: unsigned, ROWCOUNT_DATAWIDTH bits. It changes only in INIT and SHIFT and never exceeds SHIFTS_PER_LEVEL-1.

## Timing

- Reset applies at the rising edge while RESET_InLow = 0. After reset:
  - state = IDLE and state_OutBUS = 0.
  - All five strobes = 1.
  - Shift counter = 0 and the start-edge register = 1.
- Reset mid-game, in any state, forces the values above on the next edge. No strobe is issued during or after reset.
- Start latency: start sampled 0 at edge N (previous sample 1) gives INIT during cycle N+1 and COUNT from N+2.
- T0 latency: T0 sampled 0 at edge N in COUNT gives SHIFT during N+1.
  - speedClear in SHIFT zeroes the prescaler, so T0 is back to 1 by the next COUNT.
  - Each T0 pulse yields exactly one shift.
- Every one-cycle state (INIT, SHIFT, LEVELUP) is exactly one clock long.
- The LEVELUP path is COUNT, SHIFT, LEVELUP, COUNT, with upcount high for two cycles.
- Simultaneous events in COUNT: gameOver wins over start and T0; start wins over T0, so no shift occurs that cycle.
- gameOver is ignored in IDLE, INIT, SHIFT and LEVELUP. It is acted on in the next COUNT or PAUSE cycle.

## Test plan

- Reset and idle:
  - Stimulus: RESET_InLow = 0 for 2 cycles, then 1 with all inputs at 1 for 20 cycles.
  - Required: state_OutBUS = 0, all strobes 1, no transitions.
- Start sequence:
  - Stimulus: start held low for 50 cycles.
  - Required: exactly one INIT cycle with clear = 0 and speedClear = 0, then COUNT with upcount = 0 steady. The held button causes no PAUSE.
- Shift and level-up:
  - Stimulus: in COUNT, pulse T0 low for 1 cycle, 8 times, with SHIFTS_PER_LEVEL = 8.
  - Required: 8 one-cycle shift strobes, each one cycle after its T0, and one load = 0 cycle immediately after the 8th SHIFT.
  - Continue for 8 more T0 pulses: a second load pulse appears, confirming the counter wrap.
- Priority:
  - In COUNT, drive gameOver = 0, T0 = 0 and a start edge in the same cycle. Required: next state GAMEOVER (6), no shift strobe.
  - Repeat with only start edge and T0 = 0. Required: PAUSE (5), no shift.
- Pause and restart:
  - Stimulus: PAUSE, then T0 = 0 for 10 cycles, then a start edge, then gameOver = 0, then a start edge.
  - Required: in PAUSE, no strobes and no shift. Sequence is COUNT, then GAMEOVER, then INIT with the shift counter at 0.
- Reset mid-operation:
  - Stimulus: assert RESET_InLow = 0 during the SHIFT cycle and separately during LEVELUP.
  - Required: IDLE next cycle, strobes return to 1, the counter reads 0 (visible because the level-up comes after a full 8 shifts following a restart).

Source files
------------

// File: rtl/sc_statemachine_backg.sv
// Background game sequencer: Moore FSM that turns debounced start presses and
// the speed comparator's terminal flag into active-low strobes for the speed
// prescaler, the level register and the background shift registers.
module sc_statemachine_backg #(
    parameter int SHIFTS_PER_LEVEL   = 8,
    parameter int ROWCOUNT_DATAWIDTH = 4
) (
    input  logic       SC_STATEMACHINEBACKG_CLOCK_50,
    input  logic       SC_STATEMACHINEBACKG_RESET_InLow,
    input  logic       SC_STATEMACHINEBACKG_startButton_InLow,
    input  logic       SC_STATEMACHINEBACKG_T0_InLow,
    input  logic       SC_STATEMACHINEBACKG_gameOver_InLow,
    output logic       SC_STATEMACHINEBACKG_clear_OutLow,
    output logic       SC_STATEMACHINEBACKG_load_OutLow,
    output logic       SC_STATEMACHINEBACKG_upcount_OutLow,
    output logic       SC_STATEMACHINEBACKG_speedClear_OutLow,
    output logic       SC_STATEMACHINEBACKG_shift_OutLow,
    output logic [2:0] SC_STATEMACHINEBACKG_state_OutBUS
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        COUNT    = 3'd2,
        SHIFT    = 3'd3,
        LEVELUP  = 3'd4,
        PAUSE    = 3'd5,
        GAMEOVER = 3'd6,
        ILLEGAL  = 3'd7
    } state_t;

    localparam logic [ROWCOUNT_DATAWIDTH-1:0] LAST_SHIFT =
        ROWCOUNT_DATAWIDTH'(SHIFTS_PER_LEVEL - 1);

    logic                          clk;
    logic                          rst_n;
    logic                          start_n;
    logic                          t0_n;
    logic                          game_over_n;

    state_t                        state;
    state_t                        state_next;
    logic                          start_prev;
    logic                          start_edge;
    logic [ROWCOUNT_DATAWIDTH-1:0] shift_cnt;
    logic                          last_shift;

    assign clk         = SC_STATEMACHINEBACKG_CLOCK_50;
    assign rst_n       = SC_STATEMACHINEBACKG_RESET_InLow;
    assign start_n     = SC_STATEMACHINEBACKG_startButton_InLow;
    assign t0_n        = SC_STATEMACHINEBACKG_T0_InLow;
    assign game_over_n = SC_STATEMACHINEBACKG_gameOver_InLow;

    // A press is the 1 -> 0 transition of the debounced button; holding it
    // down yields a single edge.
    assign start_edge = start_prev & ~start_n;
    assign last_shift = (shift_cnt == LAST_SHIFT);

    // Remember the previous start sample for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_prev <= 1'b1;
        end else begin
            start_prev <= start_n;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shifts since the last level-up; only INIT and SHIFT touch it, and it
    // wraps to 0 on the shift that triggers LEVELUP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_cnt <= '0;
        end else if (state == INIT) begin
            shift_cnt <= '0;
        end else if (state == SHIFT) begin
            if (last_shift) begin
                shift_cnt <= '0;
            end else begin
                shift_cnt <= shift_cnt + 1'b1;
            end
        end
    end

    // Next-state logic; gameOver beats start, start beats T0 in COUNT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_edge) state_next = INIT;
            end
            INIT: begin
                state_next = COUNT;
            end
            COUNT: begin
                if (!game_over_n)     state_next = GAMEOVER;
                else if (start_edge)  state_next = PAUSE;
                else if (!t0_n)       state_next = SHIFT;
            end
            SHIFT: begin
                state_next = last_shift ? LEVELUP : COUNT;
            end
            LEVELUP: begin
                state_next = COUNT;
            end
            PAUSE: begin
                if (!game_over_n)     state_next = GAMEOVER;
                else if (start_edge)  state_next = COUNT;
            end
            GAMEOVER: begin
                if (start_edge) state_next = INIT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore output decode: every strobe idles high unless its state drives it.
    always_comb begin
        SC_STATEMACHINEBACKG_clear_OutLow      = 1'b1;
        SC_STATEMACHINEBACKG_load_OutLow       = 1'b1;
        SC_STATEMACHINEBACKG_upcount_OutLow    = 1'b1;
        SC_STATEMACHINEBACKG_speedClear_OutLow = 1'b1;
        SC_STATEMACHINEBACKG_shift_OutLow      = 1'b1;
        SC_STATEMACHINEBACKG_state_OutBUS      = state;
        case (state)
            INIT: begin
                SC_STATEMACHINEBACKG_clear_OutLow      = 1'b0;
                SC_STATEMACHINEBACKG_speedClear_OutLow = 1'b0;
            end
            COUNT: begin
                SC_STATEMACHINEBACKG_upcount_OutLow    = 1'b0;
            end
            SHIFT: begin
                SC_STATEMACHINEBACKG_shift_OutLow      = 1'b0;
                SC_STATEMACHINEBACKG_speedClear_OutLow = 1'b0;
            end
            LEVELUP: begin
                SC_STATEMACHINEBACKG_load_OutLow       = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sc_statemachine_backg.sv
// Directed bench for the background game sequencer.
module tb_sc_statemachine_backg;

    logic       clk;
    logic       rst_n;
    logic       start_n;
    logic       t0_n;
    logic       game_over_n;
    logic       clear_n;
    logic       load_n;
    logic       upcount_n;
    logic       speed_clear_n;
    logic       shift_n;
    logic [2:0] state;

    int n_checks;
    int n_fail;

    // Strobe pack order: {clear, load, upcount, speedClear, shift}
    localparam logic [4:0] S_NONE  = 5'b11111;
    localparam logic [4:0] S_INIT  = 5'b01101;
    localparam logic [4:0] S_COUNT = 5'b11011;
    localparam logic [4:0] S_SHIFT = 5'b11100;
    localparam logic [4:0] S_LVL   = 5'b10111;

    logic [4:0] strb;
    assign strb = {clear_n, load_n, upcount_n, speed_clear_n, shift_n};

    sc_statemachine_backg #(
        .SHIFTS_PER_LEVEL   (8),
        .ROWCOUNT_DATAWIDTH (4)
    ) dut (
        .SC_STATEMACHINEBACKG_CLOCK_50          (clk),
        .SC_STATEMACHINEBACKG_RESET_InLow       (rst_n),
        .SC_STATEMACHINEBACKG_startButton_InLow (start_n),
        .SC_STATEMACHINEBACKG_T0_InLow          (t0_n),
        .SC_STATEMACHINEBACKG_gameOver_InLow    (game_over_n),
        .SC_STATEMACHINEBACKG_clear_OutLow      (clear_n),
        .SC_STATEMACHINEBACKG_load_OutLow       (load_n),
        .SC_STATEMACHINEBACKG_upcount_OutLow    (upcount_n),
        .SC_STATEMACHINEBACKG_speedClear_OutLow (speed_clear_n),
        .SC_STATEMACHINEBACKG_shift_OutLow      (shift_n),
        .SC_STATEMACHINEBACKG_state_OutBUS      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs set afterwards are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic [2:0] s, input logic [4:0] st);
        check_val({tag, "_state"}, {29'd0, state}, {29'd0, s});
        check_val({tag, "_strobes"}, {27'd0, strb}, {27'd0, st});
    endtask

    // One T0 pulse from COUNT: SHIFT next cycle, then COUNT or LEVELUP->COUNT.
    task automatic t0_pulse(input bit lvl, input string tag);
        t0_n = 1'b0;
        step();
        expect_st({tag, "_shift"}, 3'd3, S_SHIFT);
        t0_n = 1'b1;
        step();
        if (lvl) begin
            expect_st({tag, "_levelup"}, 3'd4, S_LVL);
            step();
        end
        expect_st({tag, "_count"}, 3'd2, S_COUNT);
    endtask

    // Start press from IDLE/GAMEOVER: INIT for one cycle, then COUNT.
    task automatic start_game(input string tag);
        start_n = 1'b0;
        step();
        expect_st({tag, "_init"}, 3'd1, S_INIT);
        start_n = 1'b1;
        step();
        expect_st({tag, "_count"}, 3'd2, S_COUNT);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        start_n     = 1'b1;
        t0_n        = 1'b1;
        game_over_n = 1'b1;

        // Reset and idle
        step();
        step();
        expect_st("reset", 3'd0, S_NONE);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            expect_st("idle", 3'd0, S_NONE);
        end

        // Held start: one INIT, then steady COUNT, no PAUSE
        start_n = 1'b0;
        step();
        expect_st("held_init", 3'd1, S_INIT);
        for (int i = 0; i < 49; i++) begin
            step();
            expect_st("held_count", 3'd2, S_COUNT);
        end
        start_n = 1'b1;
        step();
        expect_st("release_count", 3'd2, S_COUNT);

        // Two full levels of shifts: load after 8th and 16th
        for (int i = 0; i < 16; i++) begin
            t0_pulse((i % 8) == 7, "lvl");
        end

        // Leave the counter mid-level so the restart has something to clear
        for (int i = 0; i < 3; i++) t0_pulse(1'b0, "pre");

        // Priority: gameOver + start + T0 together
        game_over_n = 1'b0;
        start_n     = 1'b0;
        t0_n        = 1'b0;
        step();
        expect_st("prio_go", 3'd6, S_NONE);
        game_over_n = 1'b1;
        start_n     = 1'b1;
        t0_n        = 1'b1;
        step();
        expect_st("go_hold", 3'd6, S_NONE);
        start_game("restart1");

        // Priority: start + T0 together -> PAUSE, no shift
        start_n = 1'b0;
        t0_n    = 1'b0;
        step();
        expect_st("prio_pause", 3'd5, S_NONE);
        start_n = 1'b1;

        // PAUSE ignores T0
        for (int i = 0; i < 10; i++) begin
            step();
            expect_st("pause_t0", 3'd5, S_NONE);
        end
        t0_n = 1'b1;
        start_n = 1'b0;
        step();
        expect_st("resume", 3'd2, S_COUNT);
        start_n = 1'b1;
        step();
        game_over_n = 1'b0;
        step();
        expect_st("gameover", 3'd6, S_NONE);
        game_over_n = 1'b1;
        start_game("restart2");

        // Counter restarted at 0: exactly 8 shifts to level-up
        for (int i = 0; i < 8; i++) t0_pulse(i == 7, "after_restart");

        // Reset during SHIFT
        for (int i = 0; i < 3; i++) t0_pulse(1'b0, "mid");
        t0_n = 1'b0;
        step();
        expect_st("rst_shift_pre", 3'd3, S_SHIFT);
        t0_n  = 1'b1;
        rst_n = 1'b0;
        step();
        expect_st("rst_in_shift", 3'd0, S_NONE);
        rst_n = 1'b1;
        step();
        expect_st("rst_shift_idle", 3'd0, S_NONE);
        start_game("restart3");

        // Reset during LEVELUP
        for (int i = 0; i < 7; i++) t0_pulse(1'b0, "to_lvl");
        t0_n = 1'b0;
        step();
        expect_st("rst_lvl_shift", 3'd3, S_SHIFT);
        t0_n = 1'b1;
        step();
        expect_st("rst_lvl_pre", 3'd4, S_LVL);
        rst_n = 1'b0;
        step();
        expect_st("rst_in_lvl", 3'd0, S_NONE);
        rst_n = 1'b1;
        step();
        expect_st("rst_lvl_idle", 3'd0, S_NONE);
        start_game("restart4");
        for (int i = 0; i < 8; i++) t0_pulse(i == 7, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
